// File: rtl/gray_pkg.sv
// Shared widths and FSM encodings for the ping-pong gray frame server.
package gray_pkg;

   localparam int GRAY_DATA_W = 8;
   localparam int GRAY_ADDR_W = 6;

   localparam logic [0:0] WR_FILL  = 1'b0;
   localparam logic [0:0] WR_WAIT  = 1'b1;

   localparam logic [0:0] RD_IDLE  = 1'b0;
   localparam logic [0:0] RD_SERVE = 1'b1;

endpackage

// File: rtl/gray_pingpong_ram.sv
// Two frame banks in one array: posedge write port, negedge read port with held output.
module gray_pingpong_ram
   import gray_pkg::*;
#(
   parameter int DATA_W = GRAY_DATA_W,
   parameter int ADDR_W = GRAY_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              wr_bank,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic              rd_bank,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2 * (2 ** ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[{wr_bank, wr_addr}] <= wr_data;
      end
   end

   // Negedge capture gives the consumer its data half a cycle after the request.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= mem[{rd_bank, rd_addr}];
      end
   end

endmodule

// File: rtl/gray_server.sv
// Ping-pong frame buffer: raster pixels fill one bank while the consumer reads the other.
module gray_server
   import gray_pkg::*;
#(
   parameter int DATA_W = GRAY_DATA_W,
   parameter int ADDR_W = GRAY_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              gray_req,
   input  logic [ADDR_W-1:0] gray_addr,
   output logic [DATA_W-1:0] gray_data,
   output logic              frame_rdy,
   input  logic              finish
);

   logic [0:0]        wr_state_reg, wr_state_next;
   logic [0:0]        rd_state_reg, rd_state_next;
   logic              wr_bank_reg, wr_bank_next;
   logic [ADDR_W-1:0] wcnt_reg, wcnt_next;
   logic              in_ready_reg;
   logic              finish_q_reg;

   logic accept;
   logic last_px;
   logic fin_rise;
   logic handoff;

   assign accept   = in_valid & in_ready_reg;
   assign last_px  = (wcnt_reg == {ADDR_W{1'b1}});
   assign fin_rise = finish & ~finish_q_reg;
   // A full write bank moves to the reader whenever the reader holds nothing.
   assign handoff  = (wr_state_reg == WR_WAIT) && (rd_state_reg == RD_IDLE);

   always_comb begin
      wr_state_next = wr_state_reg;
      rd_state_next = rd_state_reg;
      wr_bank_next  = wr_bank_reg;
      wcnt_next     = wcnt_reg;
      if (accept) begin
         wcnt_next = wcnt_reg + 1'b1;
         if (last_px) begin
            wr_state_next = WR_WAIT;
         end
      end
      if ((rd_state_reg == RD_SERVE) && fin_rise) begin
         rd_state_next = RD_IDLE;
      end
      if (handoff) begin
         wr_state_next = WR_FILL;
         rd_state_next = RD_SERVE;
         wr_bank_next  = ~wr_bank_reg;
         wcnt_next     = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_state_reg <= WR_FILL;
         rd_state_reg <= RD_IDLE;
         wr_bank_reg  <= 1'b0;
         wcnt_reg     <= '0;
         in_ready_reg <= 1'b0;
         finish_q_reg <= 1'b0;
      end else begin
         wr_state_reg <= wr_state_next;
         rd_state_reg <= rd_state_next;
         wr_bank_reg  <= wr_bank_next;
         wcnt_reg     <= wcnt_next;
         in_ready_reg <= (wr_state_next == WR_FILL);
         finish_q_reg <= finish;
      end
   end

   assign in_ready  = in_ready_reg;
   assign frame_rdy = (rd_state_reg == RD_SERVE);

   // The read bank is always the one the writer does not own.
   gray_pingpong_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (accept),
      .wr_bank (wr_bank_reg),
      .wr_addr (wcnt_reg),
      .wr_data (in_data),
      .rd_en   (gray_req),
      .rd_bank (~wr_bank_reg),
      .rd_addr (gray_addr),
      .rd_data (gray_data)
   );

endmodule

// File: tb/tb_gray_server.sv
// Scoreboard bench for gray_server: frame streaming, handoff timing, finish edges, reset.
module tb_gray_server;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       gray_req;
   logic [5:0] gray_addr;
   logic [7:0] gray_data;
   logic       frame_rdy;
   logic       finish;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] sb_q[$];

   gray_server dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .gray_req  (gray_req),
      .gray_addr (gray_addr),
      .gray_data (gray_data),
      .frame_rdy (frame_rdy),
      .finish    (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference pixel value for pixel idx of a frame of the given kind.
   function automatic logic [7:0] pix(input int kind, input int idx);
      case (kind)
         0:       return 8'(idx);
         1:       return 8'(255 - idx);
         2:       return 8'(idx) ^ 8'h5A;
         3:       return 8'(idx + 128);
         default: return 8'(idx * 7 + kind * 13);
      endcase
   endfunction

   task automatic stream(input int kind, input int first, input int count,
                         input int rate, input bit fin_on_last);
      int n   = first;
      int cyc = 0;
      bit rdy;
      while (n < first + count && cyc < 4000) begin
         in_valid = ($urandom_range(0, 99) < rate);
         in_data  = pix(kind, n);
         rdy      = in_ready;
         if (fin_on_last && n == first + count - 1 && rdy && in_valid) finish = 1'b1;
         tick();
         if (in_valid && rdy) n++;
         cyc++;
      end
      in_valid = 1'b0;
      check("stream_accepts", 32'(n - first), 32'(count));
      $display("stream kind=%0d px %0d..%0d accepted in %0d cycles", kind, first, n - 1, cyc);
   endtask

   task automatic wait_rdy(input int limit, input string tag);
      int c = 0;
      while (!frame_rdy && c < limit) begin
         tick();
         c++;
      end
      check(tag, 32'(frame_rdy), 32'd1);
   endtask

   task automatic read_one(input int addr, input logic [7:0] exp, input string tag);
      logic [7:0] e;
      sb_q.push_back(exp);
      gray_req  = 1'b1;
      gray_addr = 6'(addr);
      tick();
      gray_req = 1'b0;
      e = sb_q.pop_front();
      check(tag, 32'(gray_data), 32'(e));
      $display("read addr=%0d data=%02h", addr, gray_data);
   endtask

   // Back-to-back reads of a whole frame in a scrambled address order.
   task automatic read_frame(input int kind, output logic [7:0] last);
      int off = int'($urandom_range(0, 63));
      int a;
      logic [7:0] e;
      last = 8'h00;
      for (int i = 0; i < 64; i++) begin
         a = (i * 37 + off) % 64;
         sb_q.push_back(pix(kind, a));
         gray_req  = 1'b1;
         gray_addr = 6'(a);
         tick();
         e = sb_q.pop_front();
         check("frame_px", 32'(gray_data), 32'(e));
         last = e;
      end
      gray_req = 1'b0;
      $display("frame kind=%0d read 64 px", kind);
   endtask

   initial begin
      int         low_cnt;
      logic [7:0] last;

      reset     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      gray_req  = 1'b0;
      gray_addr = 6'd0;
      finish    = 1'b0;

      // Reset state and first-edge ready
      repeat (3) tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_frame_rdy", 32'(frame_rdy), 32'd0);
      check("rst_gray_data", 32'(gray_data), 32'd0);
      reset = 1'b1;
      tick();
      check("ready_after_rst", 32'(in_ready), 32'd1);
      check("no_frame_after_rst", 32'(frame_rdy), 32'd0);

      // Frame A: 0x00..0x3F, valid held high
      stream(0, 0, 64, 100, 1'b0);
      check("a_ready_drop", 32'(in_ready), 32'd0);
      wait_rdy(2, "a_frame_rdy");
      check("a_writer_refill", 32'(in_ready), 32'd1);
      read_one(37, 8'h25, "a_addr37");
      read_one(0, 8'h00, "a_addr0");
      read_one(63, 8'h3F, "a_addr63");

      // Frame B fills the second bank while A is still served
      stream(1, 0, 64, 100, 1'b0);
      check("b_ready_drop", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("wait_in_ready", 32'(in_ready), 32'd0);
         check("wait_frame_rdy", 32'(frame_rdy), 32'd1);
      end
      in_valid = 1'b0;
      read_one(37, 8'h25, "still_a_addr37");

      // finish held high for 20 cycles releases exactly one frame
      finish = 1'b1;
      tick();
      check("rel_low", 32'(frame_rdy), 32'd0);
      low_cnt = 1;
      for (int i = 1; i < 20; i++) begin
         tick();
         if (!frame_rdy) low_cnt++;
      end
      check("rel_low_cycles", 32'(low_cnt), 32'd1);
      check("rel_in_ready", 32'(in_ready), 32'd1);
      read_one(0, 8'hFF, "b_addr0");
      read_one(63, 8'hC0, "b_addr63");
      finish = 1'b0;
      tick();

      // finish edge on the same cycle as the last pixel of frame C
      stream(2, 0, 64, 100, 1'b1);
      check("same_frame_rdy_low", 32'(frame_rdy), 32'd0);
      check("same_in_ready", 32'(in_ready), 32'd0);
      finish = 1'b0;
      tick();
      check("same_frame_rdy_back", 32'(frame_rdy), 32'd1);
      read_frame(2, last);
      repeat (2) tick();
      check("gray_data_hold", 32'(gray_data), 32'(last));

      // Reset after 30 pixels of frame D
      stream(3, 0, 30, 100, 1'b0);
      read_one(5, pix(2, 5), "c_before_rst");
      reset = 1'b0;
      #1;
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      check("mid_rst_frame_rdy", 32'(frame_rdy), 32'd0);
      check("mid_rst_gray_data", 32'(gray_data), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("re_ready", 32'(in_ready), 32'd1);
      stream(4, 0, 63, 100, 1'b0);
      check("no_stale_frame", 32'(frame_rdy), 32'd0);
      stream(4, 63, 1, 100, 1'b0);
      wait_rdy(2, "e_frame_rdy");
      read_frame(4, last);

      // Release E with no frame pending, then read while idle
      finish = 1'b1;
      tick();
      finish = 1'b0;
      check("e_rel", 32'(frame_rdy), 32'd0);
      repeat (3) tick();
      check("idle_stays", 32'(frame_rdy), 32'd0);
      read_one(10, pix(4, 10), "idle_read");
      check("idle_read_rdy", 32'(frame_rdy), 32'd0);
      check("idle_read_in_ready", 32'(in_ready), 32'd1);

      // Three frames, 50% valid, against a concurrent consumer
      fork
         begin
            for (int f = 0; f < 3; f++) stream(10 + f, 0, 64, 50, 1'b0);
         end
         begin
            logic [7:0] lv;
            for (int f = 0; f < 3; f++) begin
               wait_rdy(3000, "rand_frame_rdy");
               read_frame(10 + f, lv);
               finish = 1'b1;
               tick();
               finish = 1'b0;
               check("rand_release", 32'(frame_rdy), 32'd0);
            end
         end
      join

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/gray_server.md
GRAY_SERVER -- requirements
Module: gray_server

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the pixel width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, the pixel address width; frame size is 2**ADDR_W pixels (64 pixels, 8x8).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, upstream pixel valid.
REQ-006 SHALL have port in_data, input, DATA_W, upstream pixel in raster order.
REQ-007 SHALL have port in_ready, output, 1, block can accept a pixel.
REQ-008 SHALL have port gray_req, input, 1, consumer read request.
REQ-009 SHALL have port gray_addr, input, ADDR_W, consumer read address.
REQ-010 SHALL have port gray_data, output, DATA_W, read data to the consumer.
REQ-011 SHALL have port frame_rdy, output, 1, a complete frame is available for reading.
REQ-012 SHALL have port finish, input, 1, a level from the consumer meaning it is done with the current frame.

Function
REQ-013 SHALL hold two frame banks of 2**ADDR_W x DATA_W (ping-pong), each owned by either the writer or the reader.
REQ-014 SHALL accept a pixel only on a rising clk edge where in_valid=1 and in_ready=1.
REQ-015 SHALL store each accepted pixel at write-counter address wcnt in the write bank, then increment wcnt modulo 2**ADDR_W.
REQ-016 Writer FSM SHALL have two states: FILL and WAIT.
- In FILL, in_ready=1.
- When pixel 63 is accepted, the write bank becomes full and the FSM goes to WAIT.
- WAIT returns to FILL when the other bank becomes free; ownership then swaps and wcnt=0.
- In WAIT, in_ready=0.
REQ-017 Reader FSM SHALL have two states: IDLE (frame_rdy=0) and SERVE (frame_rdy=1).
- IDLE goes to SERVE on the cycle after a full bank becomes available to the reader.
REQ-018 SHALL detect the rising edge of finish (0->1 between consecutive clk samples) while in SERVE.
- That edge frees the read bank and moves the FSM to IDLE, so frame_rdy is 0 on the next cycle.
- A finish level that stays high SHALL NOT release a second frame.
REQ-019 SHALL ignore a finish rising edge while in IDLE.
REQ-020 SHALL update gray_data on the falling edge of clk with bank[read][gray_addr] when gray_req=1, giving a half-cycle read latency; gray_data SHALL hold its value when gray_req=0.
REQ-021 SHALL serve gray_req while in IDLE from the last read bank, with no side effects.
REQ-022 Same-cycle events SHALL resolve as follows:
- If the write bank completes while the reader is in IDLE with no frame, that bank is handed to the reader: frame_rdy=1 and the writer is back in FILL on the other bank within 2 cycles, with no pixel lost.
- If a finish edge and write-bank completion occur together, the release and the handoff both occur, and frame_rdy drops for exactly 1 cycle before re-asserting.
REQ-023 SHALL keep ownership unchanged when in_valid=1 while in_ready=0; the pixel is not accepted and the upstream holds it.
REQ-024 A frame SHALL reach the reader only when all 64 pixels have been accepted; partial frames are never served.

Reset
REQ-025 While reset=0, SHALL clear asynchronously:
- wcnt=0 and writer FSM=FILL on bank 0;
- reader FSM=IDLE, read bank=1;
- in_ready=0, frame_rdy=0, gray_data=0;
- the finish edge register=0.
REQ-026 in_ready SHALL assert on the first clk edge after reset deasserts.
REQ-027 A reset in mid-frame SHALL discard all partial and full frames; bank contents need not be cleared.

Structure
REQ-028 DATA_W, ADDR_W defaults, and the writer and reader state encodings SHALL live in a shared package, gray_pkg.
REQ-029 The two banks SHALL be one sub-module, gray_pingpong_ram, with:
- a write port on posedge;
- a read port on negedge;
- a bank-select input for each port.

Verification
REQ-030 Load pixels 0..63 = 8'h00..8'h3F with in_valid held high -> in_ready drops after 64 accepts, frame_rdy=1 within 2 cycles; gray_req with addr 6'd37 -> gray_data=8'h25 at the next rising edge.
REQ-031 Stream frame A, then frame B (8'hFF-index) with the consumer idle -> frame B fills the second bank, the writer enters WAIT with in_ready=0, and frame_rdy stays 1 serving A.
REQ-032 Hold finish high for 20 cycles -> exactly one release; frame_rdy drops for 1 cycle, then re-asserts serving B (addr 0 reads 8'hFF); in_ready returns to 1.
REQ-033 Assert the finish rising edge on the same cycle that pixel 63 of the next frame is accepted -> no pixel lost, frame_rdy low for exactly 1 cycle.
REQ-034 Pull reset low after 30 pixels -> all outputs 0 immediately; a reload of 64 pixels yields frame_rdy=1 and the correct data, with no stale frame served.
REQ-035 Toggle in_valid randomly (50%) over 3 frames against the consumer model -> every read matches the reference frame and no over-accept occurs while in_ready=0.
